// File: rtl/tile_lookup.sv
// Writable path-tile table with per-request rotation.
// Two-stage valid/ready pipeline: table capture, then bitmap render.
module tile_lookup #(
  parameter int IDX_W  = 3,
  parameter int TILE_N = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [IDX_W-1:0]           req_idx,
  input  logic [1:0]                 req_rot,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [TILE_N*TILE_N-1:0]   rsp_tile,
  output logic [3:0]                 rsp_edges,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [4:0]                 wr_data
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int NB    = TILE_N * TILE_N;
  localparam int M     = (TILE_N - 1) / 2;

  typedef struct packed {
    logic       dead;
    logic [3:0] nesw;
  } ent_t;

  function automatic ent_t rst_ent(int i);
    ent_t e;
    e = '0;
    unique case (i)
      1: e = ent_t'(5'b0_1111);
      2: e = ent_t'(5'b0_1010);
      3: e = ent_t'(5'b0_0101);
      4: e = ent_t'(5'b0_1100);
      5: e = ent_t'(5'b0_1001);
      6: e = ent_t'(5'b0_0011);
      7: e = ent_t'(5'b0_0110);
      default: e = '0;
    endcase
    return e;
  endfunction

  // Clockwise quarter turn: each opening moves to the next side.
  function automatic logic [3:0] rot_cw(
    logic [3:0] e,
    logic [1:0] q
  );
    logic [3:0] r;
    r = e;
    unique case (q)
      2'd0: r = e;
      2'd1: r = {e[0], e[3:1]};
      2'd2: r = {e[1:0], e[3:2]};
      2'd3: r = {e[2:0], e[3]};
    endcase
    return r;
  endfunction

  ent_t       tbl [DEPTH];
  logic       s1_valid;
  ent_t       s1_ent;
  logic [1:0] s1_rot;
  logic       adv;
  logic       accept;
  logic [3:0] s2_edges;
  logic [NB-1:0] s2_tile;

  assign adv       = !rsp_valid || rsp_ready;
  assign req_ready = !s1_valid || adv;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= rst_ent(i);
      end
    end else if (wr_en) begin
      tbl[wr_idx] <= ent_t'(wr_data);
    end
  end

  // Entry is snapshotted here so later writes cannot touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ent   <= '0;
      s1_rot   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_ent   <= tbl[req_idx];
      s1_rot   <= req_rot;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  assign s2_edges = rot_cw(s1_ent.nesw, s1_rot);

  for (genvar r = 0; r < TILE_N; r++) begin : g_row
    for (genvar c = 0; c < TILE_N; c++) begin : g_col
      localparam int B = NB - 1 - (r * TILE_N + c);
      if (r == M && c == M) begin : g_ctr
        assign s2_tile[B] = (|s2_edges) & ~s1_ent.dead;
      end else if (c == M && r < M) begin : g_n
        assign s2_tile[B] = s2_edges[3];
      end else if (c == M) begin : g_s
        assign s2_tile[B] = s2_edges[1];
      end else if (r == M && c > M) begin : g_e
        assign s2_tile[B] = s2_edges[2];
      end else if (r == M) begin : g_w
        assign s2_tile[B] = s2_edges[0];
      end else begin : g_off
        assign s2_tile[B] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_tile  <= '0;
      rsp_edges <= '0;
    end else if (adv) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_tile  <= s2_tile;
        rsp_edges <= s2_edges;
      end
    end
  end

endmodule

// File: tb/tb_tile_lookup.sv
// Bench for tile_lookup: directed steps plus random traffic
// scored against a queue-based reference model.
module tb_tile_lookup;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_idx;
  logic [1:0] req_rot;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [8:0] rsp_tile;
  logic [3:0] rsp_edges;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [4:0] wr_data;

  logic        b_req_valid;
  logic        b_req_ready;
  logic [2:0]  b_req_idx;
  logic [1:0]  b_req_rot;
  logic        b_rsp_valid;
  logic        b_rsp_ready;
  logic [24:0] b_rsp_tile;
  logic [3:0]  b_rsp_edges;
  logic        b_wr_en;
  logic [2:0]  b_wr_idx;
  logic [4:0]  b_wr_data;

  tile_lookup #(.IDX_W(3), .TILE_N(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_idx(req_idx), .req_rot(req_rot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_tile(rsp_tile), .rsp_edges(rsp_edges),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
  );

  tile_lookup #(.IDX_W(3), .TILE_N(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_idx(b_req_idx), .req_rot(b_req_rot),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_tile(b_rsp_tile), .rsp_edges(b_rsp_edges),
    .wr_en(b_wr_en), .wr_idx(b_wr_idx), .wr_data(b_wr_data)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [24:0] tile;
    logic [3:0]  edges;
  } rsp_t;

  logic [4:0] mtab [8];
  rsp_t       q [$];
  bit         shown;
  bit         exp_ready;

  function automatic logic [3:0] rot_edges(logic [3:0] e, int rot);
    logic n, ee, s, w, t;
    n = e[3]; ee = e[2]; s = e[1]; w = e[0];
    for (int k = 0; k < rot; k++) begin
      t = w; w = s; s = ee; ee = n; n = t;
    end
    return {n, ee, s, w};
  endfunction

  function automatic logic [24:0] bitmap(logic [4:0] ent, int rot, int n);
    logic [3:0]  e;
    logic [24:0] o;
    int m;
    bit px;
    e = rot_edges(ent[3:0], rot);
    m = (n - 1) / 2;
    o = '0;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        px = 0;
        if (c == m && r < m && e[3]) px = 1;
        if (c == m && r > m && e[1]) px = 1;
        if (r == m && c > m && e[2]) px = 1;
        if (r == m && c < m && e[0]) px = 1;
        if (r == m && c == m && e != 0 && !ent[4]) px = 1;
        o[n*n-1-(r*n+c)] = px;
      end
    end
    return o;
  endfunction

  task automatic model_reset();
    mtab = '{5'b00000, 5'b01111, 5'b01010, 5'b00101,
             5'b01100, 5'b01001, 5'b00011, 5'b00110};
    q.delete();
    shown = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check DUT against model, cross one edge, advance the model.
  task automatic tick(input string tag);
    rsp_t it;
    int n;
    bit adv, had_s1;
    #1;
    n = q.size();
    had_s1 = n > int'(shown);
    adv = !shown || rsp_ready;
    exp_ready = !had_s1 || adv;
    chk({tag, "/rdy"}, req_ready, exp_ready);
    chk({tag, "/vld"}, rsp_valid, shown);
    if (shown) begin
      chk({tag, "/tile"}, rsp_tile, q[0].tile);
      chk({tag, "/edges"}, rsp_edges, q[0].edges);
    end
    @(posedge clk);
    if (shown && rsp_ready) void'(q.pop_front());
    if (adv) shown = had_s1;
    if (req_valid && exp_ready) begin
      it.tile  = bitmap(mtab[req_idx], int'(req_rot), 3);
      it.edges = rot_edges(mtab[req_idx][3:0], int'(req_rot));
      q.push_back(it);
    end
    if (wr_en) mtab[wr_idx] = wr_data;
    #1;
  endtask

  task automatic req(input bit v, input int idx, input int rot);
    req_valid = v;
    req_idx   = 3'(idx);
    req_rot   = 2'(rot);
  endtask

  task automatic drain(input string tag);
    req_valid = 0;
    wr_en = 0;
    rsp_ready = 1;
    for (int i = 0; i < 3; i++) tick(tag);
  endtask

  bit pat [8] = '{1, 0, 0, 1, 0, 1, 1, 1};

  initial begin
    int sent;
    rst_n = 0;
    req_valid = 0; req_idx = 0; req_rot = 0; rsp_ready = 0;
    wr_en = 0; wr_idx = 0; wr_data = 0;
    b_req_valid = 0; b_req_idx = 0; b_req_rot = 0; b_rsp_ready = 1;
    b_wr_en = 0; b_wr_idx = 0; b_wr_data = 0;
    model_reset();
    #1;
    chk("rst/vld", rsp_valid, 0);
    chk("rst/tile", rsp_tile, 0);
    chk("rst/edges", rsp_edges, 0);
    chk("rst/rdy", req_ready, 1);
    chk("rst/b_vld", b_rsp_valid, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // Single request, latency and all-open tile.
    rsp_ready = 1;
    req(1, 1, 0); tick("t1a");
    req(0, 0, 0); tick("t1b");
    chk("t1/vld", rsp_valid, 1);
    chk("t1/tile", rsp_tile, 9'b010111010);
    chk("t1/edges", rsp_edges, 4'b1111);
    drain("t1d");

    // Rotations back to back.
    req(1, 4, 1); tick("t2a");
    req(1, 2, 3); tick("t2b");
    chk("t2/tile4", rsp_tile, 9'b000011010);
    chk("t2/edge4", rsp_edges, 4'b0110);
    req(0, 0, 0); tick("t2c");
    chk("t2/tile2", rsp_tile, 9'b000111000);
    chk("t2/edge2", rsp_edges, 4'b0101);
    drain("t2d");

    // All entries under a stalling consumer.
    sent = 0;
    for (int cyc = 0; cyc < 40 && sent < 8; cyc++) begin
      req(1, sent, 0);
      rsp_ready = pat[cyc % 8];
      tick("t3");
      if (exp_ready) sent++;
    end
    chk("t3/sent", sent, 8);
    req(0, 0, 0);
    for (int cyc = 0; cyc < 20 && q.size() > 0; cyc++) begin
      rsp_ready = pat[cyc % 8];
      tick("t3d");
    end
    chk("t3/drained", q.size(), 0);
    drain("t3e");

    // Table writes and same-cycle write/read ordering.
    wr_en = 1; wr_idx = 2; wr_data = 5'b1_1010;
    tick("t4a");
    wr_en = 0;
    req(1, 2, 0); tick("t4b");
    req(0, 0, 0); tick("t4c");
    chk("t4/dead", rsp_tile, 9'b010000010);
    wr_en = 1; wr_idx = 3; wr_data = 5'b0_0000;
    req(1, 3, 0); tick("t4d");
    wr_en = 0;
    req(1, 3, 0); tick("t4e");
    chk("t4/old", rsp_tile, 9'b000111000);
    req(0, 0, 0); tick("t4f");
    chk("t4/new", rsp_tile, 9'b000000000);
    drain("t4g");

    // 5x5 instance.
    chk("t5/rdy", b_req_ready, 1);
    b_req_valid = 1; b_req_idx = 3; b_req_rot = 0;
    @(posedge clk); #1;
    b_req_idx = 6; b_req_rot = 2;
    @(posedge clk); #1;
    b_req_valid = 0;
    chk("t5/vld", b_rsp_valid, 1);
    chk("t5/tile3", b_rsp_tile, 25'b00000_00000_11111_00000_00000);
    chk("t5/mdl3", b_rsp_tile, bitmap(5'b0_0101, 0, 5));
    @(posedge clk); #1;
    chk("t5/edge6", b_rsp_edges, 4'b1100);
    chk("t5/tile6", b_rsp_tile, bitmap(5'b0_0011, 2, 5));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req($urandom_range(3) != 0, $urandom_range(7), $urandom_range(3));
      rsp_ready = $urandom_range(2) != 0;
      wr_en   = $urandom_range(7) == 0;
      wr_idx  = 3'($urandom_range(7));
      wr_data = 5'($urandom_range(31));
      tick("rnd");
    end
    drain("rndd");

    // Async reset with both stages full.
    wr_en = 1; wr_idx = 2; wr_data = 5'b1_0001;
    tick("t6w");
    wr_en = 0;
    rsp_ready = 0;
    req(1, 1, 0); tick("t6a");
    req(1, 4, 0); tick("t6b");
    req(1, 7, 0); tick("t6c");
    rst_n = 0;
    #1;
    chk("t6/vld", rsp_valid, 0);
    chk("t6/tile", rsp_tile, 0);
    chk("t6/edges", rsp_edges, 0);
    chk("t6/rdy", req_ready, 1);
    model_reset();
    req(0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("t6/rdy_rst", req_ready, 1);
    rst_n = 1;
    rsp_ready = 1;
    req(1, 5, 0); tick("t6d");
    req(1, 2, 0); tick("t6e");
    chk("t6/tile5", rsp_tile, 9'b010110000);
    req(0, 0, 0); tick("t6f");
    chk("t6/tile2", rsp_tile, 9'b010010010);
    drain("t6g");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_lookup.md
# tile_lookup

Parametrised, pipelined successor to the fixed 3x3 tile ROM. It holds a writable table of path-tile descriptors (four edge openings plus a dead-end flag) and applies a 0/90/180/270° rotation to each request. Each request produces an N×N bitmap and the rotated edge mask. It sits between the board-state logic (requester) and the VGA/LED tile renderer (consumer), behind a valid/ready handshake on both sides.

## Interface
- IDX_W, 3, table index width; table depth is 2^IDX_W entries.
- TILE_N, 3, bitmap side length; must be odd and ≥3. Centre index m = (TILE_N-1)/2.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid & req_ready.
- req_idx  in  IDX_W  table entry to render.
- req_rot  in  2  clockwise rotation in quarter turns (0..3).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response when rsp_valid & rsp_ready.
- rsp_tile  out  TILE_N*TILE_N  bitmap. Row r, column c maps to bit TILE_N*TILE_N-1-(r*TILE_N+c), so row 0 / column 0 is the MSB.
- rsp_edges  out  4  rotated openings {N,E,S,W}, with N at bit 3.
- wr_en  in  1  table write strobe.
- wr_idx  in  IDX_W  entry to write.
- wr_data  in  5  {dead, N, E, S, W}.

## Operation
- **Table:** 2^IDX_W × 5-bit registers.
  - Reset values {dead, NESW}: idx0 0_0000, idx1 0_1111, idx2 0_1010, idx3 0_0101, idx4 0_1100, idx5 0_1001, idx6 0_0011, idx7 0_0110.
  - Entries ≥8 reset to 0_0000.
- **Write:** wr_en writes wr_data to wr_idx at the clock edge. Writes are never blocked by the pipeline.
- **Stage 1:** on request accept, register entry = table[req_idx] and req_rot, and set s1_valid.
  - The entry is captured at accept. A write in the same cycle to the same index is not seen; the request gets the pre-write value.
  - Later writes never alter in-flight requests.
- **Stage 2 (output registers):** registers rotated edges e and the bitmap, and sets rsp_valid.
  - Rotation: one quarter turn gives E'=N, S'=E, W'=S, N'=W. This is applied req_rot times.
  - Bitmap bit (r,c) is set when any of the following holds:
    - c==m, r<m, and e.N
    - c==m, r>m, and e.S
    - r==m, c>m, and e.E
    - r==m, c<m, and e.W
    - r==m, c==m, at least one edge open, and dead==0
  - A dead-end tile therefore shows its edge stubs with the centre cleared.
- **Flow control:**
  - adv = !rsp_valid | rsp_ready
  - req_ready = !s1_valid | adv
  - Stage 2 loads from stage 1 when adv. rsp_valid is then set to s1_valid.
  - Stage 1 loads on accept. Otherwise it clears when it advances into stage 2.
  - While rsp_valid is set and rsp_ready is low, rsp_tile and rsp_edges hold stable.
- **Ordering:** responses come out in strict request order, with no drops or duplicates.

## Timing
- Reset (async assert): s1_valid=0, rsp_valid=0, rsp_tile=0, rsp_edges=0, table at reset values.
  - req_ready=1 during and after reset.
  - Any in-flight request is discarded.
- Latency: a request accepted at edge k gives rsp_valid=1 after edge k+1 when stage 2 is free.
- Throughput: one response per cycle with rsp_ready held at 1.
- Full condition: s1_valid=1, rsp_valid=1, rsp_ready=0 gives req_ready=0. Accept resumes in the same cycle that rsp_ready rises.
- Index wrap: not applicable. req_idx covers exactly the table depth.

## Test plan
1. After reset, req idx1 rot0 with rsp_ready=1 -> one cycle later rsp_valid=1, rsp_tile=9'b010111010, rsp_edges=4'b1111.
2. req idx4 rot1 -> rsp_edges=4'b0110, rsp_tile=9'b000011010. Then idx2 rot3 -> edges 4'b0101, tile 9'b000111000.
3. Issue idx0..7 back-to-back with rsp_ready pattern 1,0,0,1,0,1,1,1… -> eight responses in order, matching the default patterns. Check req_ready=0 exactly when both stages are full and rsp_ready=0, and that outputs are stable while stalled.
4. wr_en idx2 data 5'b1_1010, then req idx2 rot0 -> tile 9'b010000010. In the same cycle as a write of 5'b0_0000 to idx3, req idx3 -> tile 9'b000111000 (old value).
5. TILE_N=5 instance, req idx3 rot0 -> rsp_tile = 25'b00000_00000_11111_00000_00000. Then req idx6 rot2 -> edges 4'b1100.
6. Drop rst_n with both stages full -> rsp_valid and rsp_tile go to 0 without waiting for a clock edge, and written entries return to reset values. After release, a req idx5 rot0 gives tile 9'b010110000.
